// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block: addresses, funct3 encodings,
// mstatus bit positions and the read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [2:0] {
    OP_ILL0 = 3'b000,
    OP_RW   = 3'b001,
    OP_RS   = 3'b010,
    OP_RC   = 3'b011,
    OP_ILL4 = 3'b100,
    OP_RWI  = 3'b101,
    OP_RSI  = 3'b110,
    OP_RCI  = 3'b111
  } csr_op_e;

  // kind is funct3[1:0]: 01 write, 10 set, 11 clear.
  function automatic logic [31:0] csr_apply(input logic [1:0] kind,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src);
    case (kind)
      2'b01:   return src;
      2'b10:   return old_val | src;
      2'b11:   return old_val & ~src;
      default: return old_val;
    endcase
  endfunction

  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = '0;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

endpackage

// File: rtl/csr_exec_unit_cycle.sv
// Free-running 64-bit cycle counter; the first edge after reset release only
// arms the counter, so counting starts on the second edge.
module csr_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] count_o
);

  logic        started_q;
  logic [63:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_q <= 1'b0;
      count_q   <= '0;
    end else begin
      started_q <= 1'b1;
      if (started_q) begin
        count_q <= count_q + 64'd1;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_exec_unit.sv
// Machine-mode CSR file executed in the EXE stage: combinational read/legality,
// edge-committed writes, trap entry and MRET return.
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_op,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_idx,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] instret,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_req,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  logic [63:0] cycle_cnt;

  csr_cycle_counter u_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .count_o (cycle_cnt)
  );

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;

  csr_op_e     op;
  logic        op_ok, wr_try, addr_impl, addr_ro, illegal, wr_en;
  logic [31:0] old_val, src_val, new_val;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    old_val   = '0;
    addr_impl = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:           old_val = mstatus_pack(mst_mie_q, mst_mpie_q);
      CSR_MIE:               old_val = mie_q;
      CSR_MTVEC:             old_val = mtvec_q;
      CSR_MSCRATCH:          old_val = mscratch_q;
      CSR_MEPC:              old_val = mepc_q;
      CSR_MCAUSE:            old_val = mcause_q;
      CSR_MIP:               old_val = '0;
      CSR_CYCLE, CSR_TIME:   old_val = cycle_cnt[31:0];
      CSR_INSTRET:           old_val = instret[31:0];
      CSR_CYCLEH, CSR_TIMEH: old_val = cycle_cnt[63:32];
      CSR_INSTRETH:          old_val = instret[63:32];
      default:               addr_impl = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_RW, OP_RS, OP_RC, OP_RWI, OP_RSI, OP_RCI: op_ok = 1'b1;
      default:                                     op_ok = 1'b0;
    endcase
  end

  // Set/clear with a zero source is a pure read and never counts as a write.
  assign src_val = csr_op[2] ? {27'd0, rs1_idx} : rs1_data;
  assign wr_try  = (csr_op[1:0] == 2'b01) | (rs1_idx != 5'd0);
  assign addr_ro = (csr_addr[11:10] == 2'b11);
  assign illegal = csr_valid & (~addr_impl | ~op_ok | (wr_try & addr_ro));
  assign new_val = csr_apply(csr_op[1:0], old_val, src_val);
  assign wr_en   = csr_valid & ~stall & ~flush & ~illegal & ~trap_req & ~mret_req & wr_try;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_req) begin
      mepc_d     = trap_pc & 32'hFFFF_FFFC;
      mcause_d   = trap_cause;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_req) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mst_mie_d  = new_val[MSTATUS_MIE_BIT];
          mst_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = new_val;
        CSR_MTVEC:    mtvec_d    = new_val;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign csr_rdata   = (csr_valid & addr_impl) ? old_val : 32'd0;
  assign csr_illegal = illegal;
  assign trap_vector = {mtvec_q[31:2], 2'b00};
  assign mepc_out    = mepc_q;
  assign mie_global  = mst_mie_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed and randomized checks of csr_exec_unit against a behavioural CSR model.
module tb_csr_exec_unit;

  localparam logic [31:0] TB_MTVEC = 32'h0000_0107;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_op;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_idx;
  logic        stall, flush;
  logic [63:0] instret;
  logic        trap_req;
  logic [31:0] trap_pc, trap_cause;
  logic        mret_req;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] trap_vector, mepc_out;
  logic        mie_global;

  always #5 clk = ~clk;

  csr_exec_unit #(.MTVEC_RST(TB_MTVEC)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_valid   (csr_valid),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .rs1_data    (rs1_data),
    .rs1_idx     (rs1_idx),
    .stall       (stall),
    .flush       (flush),
    .instret     (instret),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .mret_req    (mret_req),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_vector (trap_vector),
    .mepc_out    (mepc_out),
    .mie_global  (mie_global)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit              m_mie, m_mpie;
  logic [31:0]     m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause;
  longint unsigned m_cycle;
  int              m_edges;

  task automatic m_reset();
    m_mie = 0; m_mpie = 0;
    m_mier = 0; m_mtvec = TB_MTVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cycle = 0; m_edges = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl);
    impl = 1;
    case (a)
      12'h300: return m_mpie ? (m_mie ? 32'h88 : 32'h80) : (m_mie ? 32'h08 : 32'h00);
      12'h304: return m_mier;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'd0;
      12'hC00, 12'hC01: return m_cycle[31:0];
      12'hC02: return instret[31:0];
      12'hC80, 12'hC81: return m_cycle[63:32];
      12'hC82: return instret[63:32];
      default: begin impl = 0; return 32'd0; end
    endcase
  endfunction

  function automatic bit m_write_try();
    return (csr_op == 3'b001) || (csr_op == 3'b101) || (rs1_idx != 0);
  endfunction

  function automatic bit m_illegal();
    bit impl;
    logic [31:0] unused_v;
    unused_v = m_read(csr_addr, impl);
    if (!csr_valid) return 0;
    return !impl || csr_op == 3'b000 || csr_op == 3'b100 ||
           (m_write_try() && csr_addr >= 12'hC00);
  endfunction

  // Apply one clock edge's worth of architectural effects from current inputs.
  task automatic m_commit();
    bit impl;
    logic [31:0] old_v, src, nv;
    old_v = m_read(csr_addr, impl);
    src = (csr_op >= 3'b100) ? 32'(rs1_idx) : rs1_data;
    if (csr_op == 3'b001 || csr_op == 3'b101)      nv = src;
    else if (csr_op == 3'b010 || csr_op == 3'b110) nv = old_v | src;
    else                                           nv = old_v & ~src;
    if (m_edges >= 1) m_cycle = m_cycle + 1;
    m_edges++;
    if (trap_req) begin
      m_mepc = {trap_pc[31:2], 2'b00};
      m_mcause = trap_cause;
      m_mpie = m_mie;
      m_mie = 0;
    end else if (mret_req) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (csr_valid && !stall && !flush && !m_illegal() && m_write_try()) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mier = nv;
        12'h305: m_mtvec = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = {nv[31:2], 2'b00};
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit impl;
    logic [31:0] exp_rd;
    exp_rd = m_read(csr_addr, impl);
    if (!(csr_valid && impl)) exp_rd = 0;
    chk({tag, ".rdata"}, 64'(csr_rdata), 64'(exp_rd));
    chk({tag, ".illegal"}, 64'(csr_illegal), 64'(m_illegal()));
    chk({tag, ".trap_vector"}, 64'(trap_vector), 64'({m_mtvec[31:2], 2'b00}));
    chk({tag, ".mepc"}, 64'(mepc_out), 64'(m_mepc));
    chk({tag, ".mie_global"}, 64'(mie_global), 64'(m_mie));
    $display("txn %-10s v=%0d addr=%h op=%0d rs1=%h idx=%0d stall=%0d flush=%0d trap=%0d mret=%0d rdata=%h ill=%0d",
             tag, csr_valid, csr_addr, csr_op, rs1_data, rs1_idx, stall, flush,
             trap_req, mret_req, csr_rdata, csr_illegal);
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [2:0] op,
                       input logic [31:0] d, input logic [4:0] idx);
    csr_valid = v; csr_addr = a; csr_op = op; rs1_data = d; rs1_idx = idx;
    stall = 0; flush = 0; trap_req = 0; mret_req = 0;
  endtask

  task automatic step();
    m_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [11:0] addr_tbl [16];

  initial begin
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hC00,
                 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'h301, 12'hC03, 12'h7C0};
    rst = 1;
    drive(0, 12'h000, 3'b000, 0, 0);
    instret = 64'h0000_0005_0000_0009;
    trap_pc = 0; trap_cause = 0;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset.trap_vector", 64'(trap_vector), 64'h104);
    chk("reset.mepc", 64'(mepc_out), 0);
    chk("reset.mie_global", 64'(mie_global), 0);
    chk("reset.rdata_idle", 64'(csr_rdata), 0);

    // Counter start: reads 0,1,2,3 on cycles 1..4 after release
    @(negedge clk);
    rst = 0;
    m_reset();
    drive(1, 12'hC00, 3'b010, 32'hFFFF_FFFF, 0);
    #1 check_model("cyc0");
    for (int k = 1; k <= 4; k++) begin
      step();
      #1 chk($sformatf("cycle_k%0d", k), 64'(csr_rdata), 64'(k - 1));
    end

    // Carry from low to high half
    force dut.u_cycle_counter.count_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.u_cycle_counter.count_q;
    m_cycle = 64'h0000_0000_FFFF_FFFF;
    drive(1, 12'hC80, 3'b010, 0, 0);
    step();
    #1 chk("cycleh_carry", 64'(csr_rdata), 1);
    drive(1, 12'hC00, 3'b010, 0, 0);
    #1 chk("cycle_lo_wrap", 64'(csr_rdata), 0);

    // mscratch read-modify-write
    drive(1, 12'h340, 3'b001, 32'hDEAD_BEEF, 5'd3);
    #1 check_model("rw_mscr");
    step();
    drive(1, 12'h340, 3'b010, 32'h0000_00F0, 5'd4);
    #1 chk("rs_mscr_old", 64'(csr_rdata), 64'hDEAD_BEEF);
    step();
    drive(1, 12'h340, 3'b010, 32'h1234_5678, 5'd0);
    #1 chk("mscr_final", 64'(csr_rdata), 64'hDEAD_BEFF);
    chk("mscr_ro_legal", 64'(csr_illegal), 0);

    // Illegal accesses
    drive(1, 12'hC00, 3'b001, 32'h5, 5'd1);
    #1 chk("wr_cycle_illegal", 64'(csr_illegal), 1);
    step();
    drive(1, 12'h340, 3'b100, 32'h0, 5'd1);
    #1 chk("op100_illegal", 64'(csr_illegal), 1);
    step();
    drive(1, 12'hC00, 3'b010, 32'h0, 5'd0);
    #1 chk("rs_cycle_idx0_legal", 64'(csr_illegal), 0);
    check_model("rd_cycle");
    drive(1, 12'h340, 3'b010, 32'h0, 5'd0);
    #1 chk("mscr_after_illegal", 64'(csr_rdata), 64'hDEAD_BEFF);

    // Trap beats a simultaneous CSR write, then MRET
    drive(1, 12'h300, 3'b001, 32'h0000_0008, 5'd1);
    step();
    drive(0, 12'h000, 3'b000, 0, 0);
    #1 chk("mie_set", 64'(mie_global), 1);
    drive(1, 12'h341, 3'b001, 32'hAAAA_0000, 5'd2);
    trap_req = 1; trap_pc = 32'h0000_1236; trap_cause = 32'h8000_000B;
    step();
    drive(1, 12'h341, 3'b010, 0, 0);
    #1 chk("trap_mepc", 64'(csr_rdata), 64'h1234);
    chk("trap_mepc_out", 64'(mepc_out), 64'h1234);
    chk("trap_mie", 64'(mie_global), 0);
    drive(1, 12'h300, 3'b010, 0, 0);
    #1 chk("trap_mstatus", 64'(csr_rdata), 64'h80);
    drive(1, 12'h342, 3'b010, 0, 0);
    #1 chk("trap_mcause", 64'(csr_rdata), 64'h8000_000B);
    drive(0, 12'h000, 3'b000, 0, 0);
    mret_req = 1;
    step();
    drive(1, 12'h300, 3'b010, 0, 0);
    #1 chk("mret_mstatus", 64'(csr_rdata), 64'h88);
    chk("mret_mie", 64'(mie_global), 1);

    // Stall holds mtvec while the counter runs
    drive(1, 12'hC00, 3'b010, 0, 0);
    #1 check_model("pre_stall");
    drive(1, 12'h305, 3'b001, 32'h0000_2000, 5'd1);
    stall = 1;
    step();
    drive(1, 12'h305, 3'b010, 0, 0);
    #1 chk("stall_mtvec", 64'(csr_rdata), 64'(TB_MTVEC));
    drive(1, 12'hC00, 3'b010, 0, 0);
    #1 check_model("stall_cycle");

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      csr_valid = ($urandom_range(0, 7) != 0);
      csr_addr = addr_tbl[$urandom_range(0, 15)];
      csr_op = 3'($urandom_range(0, 7));
      rs1_data = $urandom;
      rs1_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      trap_req = ($urandom_range(0, 15) == 0);
      mret_req = ($urandom_range(0, 15) == 0);
      trap_pc = $urandom;
      trap_cause = $urandom;
      instret = {32'($urandom), 32'($urandom)};
      #1 check_model($sformatf("rnd%0d", i));
      step();
    end

    // Asynchronous reset in the middle of a write
    drive(1, 12'h340, 3'b001, 32'h5555_AAAA, 5'd7);
    #1 rst = 1;
    m_reset();
    #1 check_model("async_rst");
    chk("async_rst_vec", 64'(trap_vector), 64'h104);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    drive(1, 12'h340, 3'b010, 0, 0);
    #1 chk("post_rst_mscr", 64'(csr_rdata), 0);
    check_model("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, which is the mtvec value loaded at reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port csr_valid, input, 1 bit: an EXE-stage CSR instruction is present.
REQ-005 SHALL have port csr_addr, input, 12 bits: the CSR address.
REQ-006 SHALL have port csr_op, input, 3 bits: funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-007 SHALL have port rs1_data, input, 32 bits: register operand.
REQ-008 SHALL have port rs1_idx, input, 5 bits: rs1 index, or the uimm for the I-forms.
REQ-009 SHALL have ports stall and flush, inputs, 1 bit each: the EXE stage is held or killed this cycle.
REQ-010 SHALL have port instret, input, 64 bits: the retired-instruction count from the retire counter.
REQ-011 SHALL have port trap_req, input, 1 bit, with trap_pc (32 bits) and trap_cause (32 bits): take a trap.
REQ-012 SHALL have port mret_req, input, 1 bit: an MRET instruction commits.
REQ-013 SHALL have port csr_rdata, output, 32 bits: the old CSR value, for writeback to rd.
REQ-014 SHALL have port csr_illegal, output, 1 bit: the access is illegal.
REQ-015 SHALL have ports trap_vector and mepc_out, outputs, 32 bits each: {mtvec[31:2],2'b00} and mepc.
REQ-016 SHALL have port mie_global, output, 1 bit: mstatus.MIE.

Function
REQ-017 SHALL implement these CSRs: mstatus 0x300 (only MIE bit 3 and MPIE bit 7 writable, other bits read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits [1:0] read 0), mcause 0x342, mip 0x344 (read-only, reads 0).
REQ-018 SHALL provide read-only counters: cycle 0xC00 and time 0xC01 (both alias the internal 64-bit cycle counter, low half), instret 0xC02 (instret[31:0]), and cycleh 0xC80, timeh 0xC81, instreth 0xC82 (the high halves).
REQ-019 SHALL drive csr_rdata combinationally from csr_addr in the same cycle; it SHALL be 0 when csr_valid=0 or the address is unimplemented.
REQ-020 SHALL compute the new value as: RW = src; RS = old|src; RC = old&~src; where src = rs1_data, or the zero-extended rs1_idx for the I-forms.
REQ-021 SHALL treat RS/RC/RSI/RCI with rs1_idx=0 as read-only accesses, with no write and no illegal flag.
REQ-022 SHALL assert csr_illegal combinationally when csr_valid=1 and any of the following holds: the address is unimplemented, csr_op is 000 or 100, or a write is attempted to an address with addr[11:10]=2'b11.
REQ-023 SHALL commit a CSR write at the clock edge only when csr_valid & ~stall & ~flush & ~csr_illegal & ~trap_req.
REQ-024 SHALL increment the cycle counter by 1 every cycle from the second cycle after reset release, never gated by stall/flush, and it SHALL wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-025 On trap_req at the edge it SHALL set: mepc <= {trap_pc[31:2],2'b00}, mcause <= trap_cause, MPIE <= MIE, MIE <= 0.
REQ-026 On mret_req at the edge it SHALL set MIE <= MPIE and MPIE <= 1.
REQ-027 Priority SHALL be trap_req > mret_req > CSR write; lower-priority updates in the same cycle SHALL be dropped entirely.
REQ-028 When stall=1 with no trap/mret, all CSRs except the cycle counter SHALL hold.

Reset
REQ-029 On rst it SHALL asynchronously clear all CSRs and the cycle counter to 0, except mtvec, which SHALL load MTVEC_RST.
REQ-030 The first cycle after rst deasserts SHALL NOT increment the cycle counter, so the first increment happens on the second edge.
REQ-031 An rst asserted mid-operation SHALL discard any pending write, and outputs SHALL reflect reset values immediately.

Structure
REQ-032 A shared package csr_pkg SHALL hold the CSR address localparams, the csr_op enum, and the mstatus bit indices.
REQ-033 The 64-bit cycle counter, including its reset-skip flag, SHALL live in sub-module csr_cycle_counter; all other logic SHALL reside in csr_exec_unit.

Verification
REQ-034 Reset, then read 0xC00 on cycles 1..4 after release -> rdata 0, 1, 2, 3 (the counter is delayed by one cycle).
REQ-035 Force the counter to 0x0000_0000_FFFF_FFFF and read 0xC80 one cycle later -> 0x0000_0001, with 0xC00 = 0.
REQ-036 CSRRW mscratch with rs1=0xDEAD_BEEF, then CSRRS with rs1=0x0000_00F0 -> second rdata 0xDEAD_BEEF, final mscratch 0xDEAD_BEFF.
REQ-037 Write 0xC00, or use op 100 -> csr_illegal=1 and no state change; CSRRS 0xC00 with rs1_idx=0 -> csr_illegal=0.
REQ-038 Set MIE=1, assert trap_req with trap_pc=0x0000_1236, trap_cause=0x8000_000B, and a simultaneous CSRRW mepc -> mepc 0x0000_1234, MIE=0, MPIE=1, CSR write dropped; then mret_req -> MIE=1, MPIE=1.
REQ-039 Apply stall=1 with a valid CSRRW mtvec -> mtvec unchanged while the cycle counter still advances.
